square_compose: RTL



---
 rtl/square_compose_pkg.sv | 13 +
 rtl/square_compose_div.sv | 43 ++++
 rtl/square_compose.sv | 95 +++++++++
 3 files changed

// File: rtl/square_compose_pkg.sv
// square_compose_pkg: shared state encoding, scale and widths for the fixed-point squarer.
package square_compose_pkg;
  localparam int WHOLE_W = 7;
  localparam int FRAC_W = 7;
  localparam int SCALE = 100;
  localparam int X_W = 14;
  localparam int PROD_W = 28;
  localparam int SQW_W = 14;
  localparam int MUL_CYC = 14;
  localparam int DIV_CYC = 28;
  localparam int REM_W = $clog2(SCALE);
  typedef enum logic [2:0] {IDLE, MUL, DIV1, DIV2, DONE} state_t;
endpackage

// File: rtl/square_compose_div.sv
// seq_div_const: restoring divider by a constant, one quotient bit per cycle; load folds into the first step.
module seq_div_const
  import square_compose_pkg::*;
#(
  parameter int DIVISOR = SCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              go,
  input  logic [PROD_W-1:0] dividend,
  output logic [PROD_W-1:0] quotient,
  output logic [REM_W-1:0]  remainder,
  output logic [PROD_W-1:0] quot_nxt,
  output logic [REM_W-1:0]  rem_nxt,
  output logic              last
);
  logic [PROD_W-1:0] src;
  logic [REM_W-1:0] rsrc;
  logic [REM_W:0] trial;
  logic ge;
  logic [4:0] cnt;
  always_comb begin
    src = load ? dividend : quotient;
    rsrc = load ? '0 : remainder;
    trial = {rsrc, src[PROD_W-1]};
    ge = trial >= (REM_W+1)'(DIVISOR);
    rem_nxt = ge ? REM_W'(trial - (REM_W+1)'(DIVISOR)) : trial[REM_W-1:0];
    quot_nxt = {src[PROD_W-2:0], ge};
    last = go && !load && cnt == 5'(DIV_CYC-1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient <= '0;
      remainder <= '0;
      cnt <= '0;
    end else if (go) begin
      quotient <= quot_nxt;
      remainder <= rem_nxt;
      cnt <= load ? 5'd1 : cnt + 5'd1;
    end
  end
endmodule

// File: rtl/square_compose.sv
// square_compose: squares a whole.hundredths operand via shift-add multiply and two divide-by-100 passes.
module square_compose
  import square_compose_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WHOLE_W-1:0] whole_in,
  input  logic [FRAC_W-1:0]  fracture_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SQW_W-1:0]   square_whole,
  output logic [FRAC_W-1:0]  square_fracture
);
  state_t state, nxt;
  logic fresh, bad, accept, div_go, div_load, div_last;
  logic [X_W-1:0] x, mp;
  logic [PROD_W-1:0] acc, mc, div_in, quotient, quot_nxt;
  logic [REM_W-1:0] remainder, rem_nxt;
  logic [3:0] mcnt;
  always_comb begin
    x = X_W'(whole_in) * X_W'(SCALE) + X_W'(fracture_in);
    bad = fracture_in > FRAC_W'(SCALE-1);
    accept = state == IDLE && start;
    div_go = state == DIV1 || state == DIV2;
    div_load = div_go && fresh;
    div_in = state == DIV1 ? acc : quotient;
    busy = state == MUL || div_go;
    done = state == DONE;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = start ? (bad ? DONE : MUL) : IDLE;
      MUL:  nxt = mcnt == 4'(MUL_CYC-1) ? DIV1 : MUL;
      DIV1: nxt = div_last ? DIV2 : DIV1;
      DIV2: nxt = div_last ? DONE : DIV2;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // fresh marks the first cycle of a state so each divide pass loads its dividend
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fresh <= 1'b0;
    end else begin
      state <= nxt;
      fresh <= nxt != state;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      mc <= '0;
      mp <= '0;
      mcnt <= '0;
      err <= 1'b0;
      square_whole <= '0;
      square_fracture <= '0;
    end else begin
      if (accept && bad) err <= 1'b1;
      if (accept && !bad) begin
        acc <= '0;
        mc <= PROD_W'(x);
        mp <= x;
        mcnt <= '0;
        err <= 1'b0;
      end
      if (state == MUL) begin
        acc <= acc + (mp[0] ? mc : '0);
        mc <= mc << 1;
        mp <= mp >> 1;
        mcnt <= mcnt + 4'd1;
      end
      if (state == DIV2 && div_last) begin
        square_whole <= SQW_W'(quot_nxt);
        square_fracture <= FRAC_W'(rem_nxt);
      end
    end
  end
  seq_div_const #(.DIVISOR(SCALE)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .load(div_load),
    .go(div_go),
    .dividend(div_in),
    .quotient(quotient),
    .remainder(remainder),
    .quot_nxt(quot_nxt),
    .rem_nxt(rem_nxt),
    .last(div_last)
  );
endmodule
